// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
//
// Two-master round-robin arbiter in front of a single-port DRAM with
// asynchronous read data. Each access runs IDLE -> ACCESS -> RESP, so a
// request first seen in IDLE is acknowledged two cycles later. The peak rate
// is one access every three cycles.
//
// Addresses are byte addresses. Bits [1:0] are ignored. Any set bit in
// addr[31:RANGE_HI] marks the access as out of range. Such an access never
// writes the DRAM, returns zero read data and is acknowledged with err set.
//
// Parameters
//   ADDR_W    DRAM word-address width (dram_a = addr[ADDR_W+1:2])
//   RANGE_HI  lowest address bit that must be zero for an in-range access
//
// Ports
//   cpu_clk              single clock, rising edge
//   cpu_rst_n            asynchronous active-low reset
//   m{0,1}_req           request, held until the matching ack
//   m{0,1}_we            1 = write, 0 = read
//   m{0,1}_addr[31:0]    byte address, stable while req is high and ack is low
//   m{0,1}_wdata[31:0]   write data
//   m{0,1}_ack           one-cycle completion pulse
//   m{0,1}_err           out-of-range flag, qualified by ack
//   m{0,1}_rdata[31:0]   read data, qualified by ack (zero otherwise)
//   dram_a[ADDR_W-1:0]   DRAM word address (latched)
//   dram_we              DRAM write strobe, only during an in-range write ACCESS
//   dram_d[31:0]         DRAM write data (latched)
//   dram_spo[31:0]       DRAM asynchronous read data
// -----------------------------------------------------------------------------
module dram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int RANGE_HI = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,

  output logic [ADDR_W-1:0] dram_a,
  output logic              dram_we,
  output logic [31:0]       dram_d,
  input  logic [31:0]       dram_spo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        last_gnt;   // index of the most recently granted master
  logic        gnt_idx;    // master owning the transaction in flight
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_reg;

  logic        any_req;
  logic        sel;
  logic        lat_oor;
  logic        unused_addr;

  // Grant selection. On a tie the master that did not win last time gets the
  // grant. With a single requester that requester wins. When neither master
  // requests, sel is a don't-care because any_req gates the grant.
  always_comb begin
    any_req = m0_req | m1_req;
    sel     = (m0_req && m1_req) ? ~last_gnt : m1_req;
  end

  // Range check on the latched address, shared by the write strobe and the
  // response path.
  assign lat_oor = |lat_addr[31:RANGE_HI];

  // The strobe decodes the current state rather than a register. An
  // asynchronous reset in the middle of ACCESS therefore drops it
  // immediately, before the edge that would commit the write.
  assign dram_we = (state == ACCESS) && lat_we && !lat_oor;
  assign dram_a  = lat_addr[ADDR_W+1:2];
  assign dram_d  = lat_wdata;

  // Read data reaches only the acknowledged master. The other master sees 0.
  assign m0_rdata = m0_ack ? rdata_reg : 32'd0;
  assign m1_rdata = m1_ack ? rdata_reg : 32'd0;

  // Some latched address bits (at least [1:0]) only feed this sink.
  assign unused_addr = ^lat_addr;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;       // m0 wins the first tie after reset
      gnt_idx   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rdata_reg <= 32'd0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
    end else begin
      // Acks and errs are single-cycle pulses that only the ACCESS branch raises.
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_idx   <= sel;
            last_gnt  <= sel;
            lat_we    <= sel ? m1_we    : m0_we;
            lat_addr  <= sel ? m1_addr  : m0_addr;
            lat_wdata <= sel ? m1_wdata : m0_wdata;
            state     <= ACCESS;
          end
        end

        // ---- ACCESS -> RESP: DRAM write commits, read data is captured ----
        ACCESS: begin
          rdata_reg <= (!lat_we && !lat_oor) ? dram_spo : 32'd0;
          m0_ack    <= ~gnt_idx;
          m1_ack    <= gnt_idx;
          m0_err    <= ~gnt_idx & lat_oor;
          m1_err    <= gnt_idx & lat_oor;
          state     <= RESP;
        end

        // ---- RESP -> IDLE: requests are not sampled here ----
        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

  localparam int ADDR_W   = 14;
  localparam int RANGE_HI = 16;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0]       m0_addr = '0, m0_wdata = '0;
  logic              m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0]       m1_addr = '0, m1_wdata = '0;
  logic              m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]       m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] dram_a;
  logic              dram_we;
  logic [31:0]       dram_d;
  logic [31:0]       dram_spo;

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(ADDR_W), .RANGE_HI(RANGE_HI)) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .m1_rdata  (m1_rdata),
    .dram_a    (dram_a),
    .dram_we   (dram_we),
    .dram_d    (dram_d),
    .dram_spo  (dram_spo)
  );

  // DRAM model: an unwritten word reads back as a pattern derived from its address.
  function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
    return 32'h5A5A_0000 | {{(32-ADDR_W){1'b0}}, a};
  endfunction

  logic [31:0] mem    [0:DEPTH-1];
  bit          wr_vld [0:DEPTH-1];

  assign dram_spo = wr_vld[dram_a] ? mem[dram_a] : init_val(dram_a);

  always @(posedge clk) begin
    if (dram_we) begin
      mem[dram_a]    <= dram_d;
      wr_vld[dram_a] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   we_seen = 1'b0;
  int   model_last = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic exp_t mk_exp(input int m, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.m = m;
    e.err = err;
    e.rdata = rdata;
    return e;
  endfunction

  // Scoreboard monitor: every ack pops the oldest expectation. A master that
  // is not acked must show zero err and rdata.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (dram_we) we_seen = 1'b1;
    if (m0_ack || m1_ack) begin
      check("ack_overlap", 64'(m0_ack & m1_ack), 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b, required no ack", m0_ack, m1_ack);
      end else begin
        e = sb.pop_front();
        check("ack_master", m1_ack ? 64'd1 : 64'd0, 64'(e.m));
        if (e.m == 0) begin
          check("m0_err", 64'(m0_err), 64'(e.err));
          check("m0_rdata", 64'(m0_rdata), 64'(e.rdata));
        end else begin
          check("m1_err", 64'(m1_err), 64'(e.err));
          check("m1_rdata", 64'(m1_rdata), 64'(e.rdata));
        end
      end
    end
    if (!m0_ack) check("m0_quiet", {31'd0, m0_err, m0_rdata}, 64'd0);
    if (!m1_ack) check("m1_quiet", {31'd0, m1_err, m1_rdata}, 64'd0);
  end

  // Issue one access on master m and return the cycles from request to ack.
  task automatic drive(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat);
    int start;
    bit got;
    if (m == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
    start = cyc;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
    end
    if (got) lat = cyc - start;
    else timeout_fail($sformatf("ack_wait_m%0d", m));
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[13];
    int   lat, lat0, lat1;
    int   ackn, prev, first;
    bit   found;

    vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 1'b1, 32'h0001_0000, 32'h0000_1234, 1'b1, 32'h0};
    vecs[3]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h5A5A_0000};
    vecs[4]  = '{1, 1'b1, 32'h0000_0040, 32'h1111_2222, 1'b0, 32'h0};
    vecs[5]  = '{1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h1111_2222};
    vecs[6]  = '{0, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{1, 1'b0, 32'h0000_FFFC, 32'h0,         1'b0, 32'h5A5A_3FFF};
    vecs[8]  = '{0, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1, 1'b1, 32'h0000_FFFC, 32'h0BAD_F00D, 1'b0, 32'h0};
    vecs[10] = '{1, 1'b0, 32'h0000_FFFC, 32'h0,         1'b0, 32'h0BAD_F00D};
    vecs[11] = '{0, 1'b1, 32'h0001_0040, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[12] = '{1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h1111_2222};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m0_ack", 64'(m0_ack), 64'd0);
    check("rst_m1_ack", 64'(m1_ack), 64'd0);
    check("rst_m0_err", 64'(m0_err), 64'd0);
    check("rst_m1_err", 64'(m1_err), 64'd0);
    check("rst_dram_we", 64'(dram_we), 64'd0);
    check("rst_dram_a", 64'(dram_a), 64'd0);
    check("rst_dram_d", 64'(dram_d), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous requests straight out of reset: m0 first, m1 three cycles later
    sb.push_back(mk_exp(0, 1'b0, 32'h5A5A_0040));
    sb.push_back(mk_exp(1, 1'b0, 32'h5A5A_0080));
    fork
      drive(0, 1'b0, 32'h0000_0100, 32'h0, lat0);
      drive(1, 1'b0, 32'h0000_0200, 32'h0, lat1);
    join
    check("tie_m0_latency", 64'(lat0), 64'd2);
    check("tie_m1_gap", 64'(lat1 - lat0), 64'd3);
    model_last = 1;

    // Table-driven single-master accesses
    for (int i = 0; i < 13; i++) begin
      sb.push_back(mk_exp(vecs[i].m, vecs[i].exp_err, vecs[i].exp_rdata));
      we_seen = 1'b0;
      drive(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_dram_we", i), 64'(we_seen),
            64'(vecs[i].we && !vecs[i].exp_err));
      model_last = vecs[i].m;
    end

    // Both masters hold req for six transactions: grants alternate
    first = (model_last == 1) ? 0 : 1;
    for (int k = 0; k < 6; k++) begin
      if (((k % 2 == 0) ? first : 1 - first) == 0)
        sb.push_back(mk_exp(0, 1'b0, 32'hDEAD_BEEF));
      else
        sb.push_back(mk_exp(1, 1'b0, 32'h1111_2222));
    end
    m0_we = 1'b0; m0_addr = 32'h0000_0010;
    m1_we = 1'b0; m1_addr = 32'h0000_0040;
    m0_req = 1'b1; m1_req = 1'b1;
    ackn = 0;
    prev = 0;
    for (int i = 0; i < 60 && ackn < 6; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        if (ackn > 0) check($sformatf("rr_spacing%0d", ackn), 64'(cyc - prev), 64'd3);
        prev = cyc;
        ackn++;
        if (ackn == 6) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
        end
      end
    end
    if (ackn < 6) begin
      timeout_fail("rr_six_acks");
      m0_req = 1'b0;
      m1_req = 1'b0;
    end
    @(posedge clk);
    #1;

    // Reset pulsed during a write ACCESS: no commit and no ack
    m0_we = 1'b1; m0_addr = 32'h0000_0020; m0_wdata = 32'hA5A5_A5A5; m0_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (dram_we) found = 1'b1;
    end
    if (!found) timeout_fail("rst_access_wait");
    rst_n = 1'b0;
    #1;
    check("midrst_dram_we", 64'(dram_we), 64'd0);
    check("midrst_dram_a", 64'(dram_a), 64'd0);
    check("midrst_dram_d", 64'(dram_d), 64'd0);
    check("midrst_m0_ack", 64'(m0_ack), 64'd0);
    m0_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sb.push_back(mk_exp(0, 1'b0, 32'h5A5A_0008));
    drive(0, 1'b0, 32'h0000_0020, 32'h0, lat);
    check("post_rst_latency", 64'(lat), 64'd2);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the DRAM word-address width driven on dram_a.
REQ-002 SHALL have parameter RANGE_HI, default 16, meaning that address bits [31:RANGE_HI] must be zero for an in-range access.
REQ-003 SHALL have port cpu_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port cpu_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports m0_req and m1_req, input, 1 bit each: access request; held high until the matching ack.
REQ-006 SHALL have ports m0_we and m1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr and m1_addr, input, 32 bits each: byte address; bits [1:0] are ignored.
REQ-008 SHALL have ports m0_wdata and m1_wdata, input, 32 bits each: write data.
REQ-009 SHALL have ports m0_ack and m1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have ports m0_err and m1_err, output, 1 bit each: out-of-range flag, valid only while the matching ack is high.
REQ-011 SHALL have ports m0_rdata and m1_rdata, output, 32 bits each: read data, valid only while the matching ack is high.
REQ-012 SHALL have port dram_a, output, ADDR_W bits: DRAM word address, equal to the latched addr[ADDR_W+1:2].
REQ-013 SHALL have port dram_we, output, 1 bit; dram_d, output, 32 bits; dram_spo, input, 32 bits (asynchronous read data).

Function
REQ-014 SHALL implement the states IDLE, ACCESS and RESP, with a 1-bit register last_gnt.
REQ-015 In IDLE with any request pending, the arbiter SHALL select one master, latch its we/addr/wdata and grant index, and move to ACCESS; with no request pending it SHALL stay in IDLE.
REQ-016 With only one request pending, that master SHALL be granted; with both pending, the master not equal to last_gnt SHALL be granted (round-robin).
REQ-017 last_gnt SHALL update to the granted index on every grant.
REQ-018 ACCESS SHALL last exactly one cycle, driving dram_a and dram_d from the latch.
REQ-019 dram_we SHALL equal (state==ACCESS) AND latched we AND in-range, so a write commits at the edge that ends ACCESS.
REQ-020 At the edge that ends ACCESS, rdata_reg SHALL load dram_spo for an in-range read, and 0 for a write or an out-of-range access; the FSM then moves to RESP.
REQ-021 In RESP, only the granted master's ack SHALL be 1; its err SHALL be 1 if the access is out-of-range, and its rdata SHALL equal rdata_reg.
REQ-022 RESP SHALL always return to IDLE; requests are not sampled in RESP.
REQ-023 Latency SHALL be as follows: req is first seen in IDLE in cycle N, ACCESS occurs in N+1, and ack occurs in N+2; peak throughput is one access per 3 cycles.
REQ-024 A master that keeps req high after its ack SHALL be treated as issuing a new request at the next IDLE.
REQ-025 Out-of-range is defined as addr[31:RANGE_HI] != 0; an out-of-range access SHALL never assert dram_we and SHALL still be acked.
REQ-026 The non-granted master's ack, err and rdata SHALL be 0 in every cycle.
REQ-027 While the arbiter is not in ACCESS, dram_a and dram_d SHALL hold their latched values and dram_we SHALL be 0.
REQ-028 Masters SHALL hold addr/we/wdata stable while req is high and ack is low; the arbiter latches them only at grant.

Reset
REQ-029 Asserting cpu_rst_n low SHALL immediately force the state to IDLE and the outputs m0_ack, m1_ack, m0_err, m1_err and dram_we to 0.
REQ-030 Asserting cpu_rst_n low SHALL immediately force the latch, rdata_reg, dram_a and dram_d to 0, and last_gnt to 1 so that m0 wins the first tie.
REQ-031 Reset asserted during ACCESS SHALL drop dram_we asynchronously so that no write commits; the transaction is discarded with no ack.
REQ-032 After cpu_rst_n rises, the first grant SHALL occur no earlier than the first rising edge with cpu_rst_n high.

Verification
REQ-033 Scenario 1: m0 writes 0xDEADBEEF to 0x0000_0010, then m0 reads 0x0000_0010 -> the write ack has err=0; the read ack has rdata=0xDEADBEEF; each ack occurs 2 cycles after IDLE sampling.
REQ-034 Scenario 2: m0 and m1 request in the same cycle straight out of reset -> m0 is acked first, m1 is acked 3 cycles later, and the acks never overlap.
REQ-035 Scenario 3: both masters hold req continuously for 6 transactions -> grants alternate m0, m1, m0, m1, ...; the m1 ack has rdata from m1_addr, not from m0_addr.
REQ-036 Scenario 4: m1 writes 0x1234 to 0x0001_0000 -> dram_we stays 0 throughout, m1_err=1 and m1_rdata=0 on the ack; a subsequent read of word 0 is unchanged.
REQ-037 Scenario 5: m0 writes 0xA5A5A5A5 to 0x20, and cpu_rst_n is pulsed low mid-ACCESS -> no ack is produced; a read of 0x20 after reset returns the prior contents.
